// File: rtl/pc_pkg.sv
// Shared types and default sizing for the program counter and its return stack.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } pc_state_t;

  localparam int PC_ADDR_W     = 6;
  localparam int PC_RESET_ADDR = 0;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses for call/ret; the top entry is presented combinationally.
module pc_return_stack #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  top_idx;

  assign top_idx = count - CNT_W'(1);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign top     = mem[top_idx[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= top_idx;
    end
  end

  // Entry storage carries no reset; only the occupancy count is control.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[count[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/program_counter_seq.sv
// Registered program counter with fetch/execute handshake, branch, halt and wrap pulse.
// Optional call/return stack enabled by defining PC_CALL_STACK_EN.
module program_counter_seq
  import pc_pkg::*;
#(
  parameter int ADDR_W     = PC_ADDR_W,
  parameter int RESET_ADDR = PC_RESET_ADDR,
  parameter int STEP       = 1
`ifdef PC_CALL_STACK_EN
  ,
  parameter int STACK_DEPTH = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PC_CALL_STACK_EN
  input  logic              call,
  input  logic              ret,
  output logic              stack_err,
`endif
  input  logic              start,
  input  logic              done,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] output_read_addr,
  output logic              fetch_valid,
  output logic              busy,
  output logic              halted,
  output logic              wrapped
);

  localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W:0]   STEP_EXT  = (ADDR_W + 1)'(STEP);

  pc_state_t         state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic              wrap_n;
  logic [ADDR_W:0]   seq_sum;

  // One extra bit so the carry out of the advance becomes the wrap flag.
  assign seq_sum = {1'b0, output_read_addr} + STEP_EXT;

`ifdef PC_CALL_STACK_EN
  logic              push, pop, clear, full, empty, err_n;
  logic [ADDR_W-1:0] top;

  pc_return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (seq_sum[ADDR_W-1:0]),
    .top       (top),
    .full      (full),
    .empty     (empty)
  );
`endif

  always_comb begin
    state_n = state;
    addr_n  = output_read_addr;
    wrap_n  = 1'b0;
`ifdef PC_CALL_STACK_EN
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
    err_n = stack_err;
`endif
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_n = FETCH;
          addr_n  = RESET_VAL;
`ifdef PC_CALL_STACK_EN
          clear = 1'b1;
          err_n = 1'b0;
`endif
        end
      end
      FETCH: state_n = EXEC;
      EXEC: begin
        if (done) begin
          if (halt) begin
            state_n = HALT;
`ifdef PC_CALL_STACK_EN
          end else if (ret) begin
            if (empty) begin
              err_n   = 1'b1;
              state_n = HALT;
            end else begin
              pop     = 1'b1;
              addr_n  = top;
              state_n = FETCH;
            end
          end else if (branch_en && call) begin
            if (full) begin
              err_n   = 1'b1;
              state_n = HALT;
            end else begin
              push    = 1'b1;
              addr_n  = branch_addr;
              state_n = FETCH;
            end
`endif
          end else if (branch_en) begin
            state_n = FETCH;
            addr_n  = branch_addr;
          end else begin
            state_n = FETCH;
            addr_n  = seq_sum[ADDR_W-1:0];
            wrap_n  = seq_sum[ADDR_W];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      output_read_addr <= RESET_VAL;
      fetch_valid      <= 1'b0;
      busy             <= 1'b0;
      halted           <= 1'b0;
      wrapped          <= 1'b0;
    end else begin
      state            <= state_n;
      output_read_addr <= addr_n;
      fetch_valid      <= (state_n == FETCH);
      busy             <= (state_n == FETCH) || (state_n == EXEC);
      halted           <= (state_n == HALT);
      wrapped          <= wrap_n;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stack_err <= 1'b0;
    end else begin
      stack_err <= err_n;
    end
  end
`endif

endmodule

// File: doc/program_counter_seq.md
Name: program_counter_seq

Overview:
- Parametrised successor to the simple CPU's combinational read-address counter.
- Registered program counter with a fetch/execute handshake FSM, branch load, halt and wrap detection.
- Sits between the control unit (start/done/branch/halt) and the instruction RAM read port (output_read_addr).

Parameters:
ADDR_W, 6, width of instruction RAM address.
RESET_ADDR, 0, address loaded on reset and on every start (must fit in ADDR_W bits).
STEP, 1, increment applied on sequential advance (1..2^ADDR_W-1).
STACK_DEPTH, 4, return-stack entries (used only with the optional feature).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
start  input  1  begin execution from RESET_ADDR (sampled in IDLE or HALT).
done  input  1  current instruction complete (sampled in EXEC only).
branch_en  input  1  with done: take branch_addr instead of sequential advance.
branch_addr  input  ADDR_W  branch target.
halt  input  1  with done: stop after this instruction.
output_read_addr  output  ADDR_W  registered RAM read address.
fetch_valid  output  1  one-cycle pulse; output_read_addr is valid for a fetch.
busy  output  1  high in FETCH or EXEC.
halted  output  1  high in HALT.
wrapped  output  1  one-cycle pulse when a sequential advance overflows past 2^ADDR_W-1.

Behaviour:
- Reset: the one clock and a synchronous, active-high reset; reset is sampled only on the rising clk edge and overrides every other input, including mid-FETCH or mid-EXEC.
- Reset values: state=IDLE, output_read_addr=RESET_ADDR, fetch_valid=0, busy=0, halted=0, wrapped=0.
- States: IDLE, FETCH, EXEC, HALT (2-bit encoding).
- IDLE: on start -> FETCH, output_read_addr<=RESET_ADDR. Other inputs are ignored.
- FETCH: lasts exactly one cycle; fetch_valid=1 during it; then -> EXEC unconditionally.
- EXEC: holds the address until done=1. On done, evaluated in priority order:
  - halt=1 -> HALT, address held. Halt beats branch.
  - branch_en=1 -> FETCH, address<=branch_addr.
  - otherwise -> FETCH, address<=(address+STEP) mod 2^ADDR_W. wrapped pulses in the FETCH cycle if the unmodded sum >= 2^ADDR_W.
- Branch never asserts wrapped.
- HALT: halted=1, address frozen. start -> FETCH from RESET_ADDR. done, branch_en and halt are ignored.
- start in FETCH or EXEC is ignored (no restart mid-instruction).
- Minimum instruction period is 2 cycles: done held high continuously gives a fetch_valid pulse every other cycle.
- All outputs are registered; there is no combinational input-to-output path.
- Arithmetic is unsigned, computed ADDR_W+1 bits wide, and truncated to ADDR_W.

Optional Feature:
Macro PC_CALL_STACK_EN.
- Defined:
  - Adds ports call (in, 1), ret (in, 1) and stack_err (out, 1).
  - call with done and branch_en pushes address+STEP (mod) onto a STACK_DEPTH-entry LIFO, then branches.
  - ret with done pops the top entry into the address; ret takes priority over branch_en, call and sequential advance.
  - Push when full or pop when empty sets sticky stack_err and goes to HALT.
  - halt beats ret and call.
  - Reset and start empty the stack and clear stack_err.
- Undefined: these ports and the stack logic are absent; behaviour is exactly as above.

Decomposition:
- Shared package pc_pkg:
  - state enum pc_state_t {IDLE, FETCH, EXEC, HALT}.
  - Default ADDR_W and RESET_ADDR constants for the CPU top.
- Sub-module pc_return_stack (push/pop/full/empty, STACK_DEPTH x ADDR_W). Instantiated only under PC_CALL_STACK_EN.

Test Plan:
- Reset, then start; done pulsed each EXEC -> fetch_valid pulses at addresses 0,1,2,3; busy=1, halted=0.
- ADDR_W=6, address 63, done with no branch -> address 0, wrapped=1 for exactly one cycle. STEP=4 from 62 -> 2 with wrapped=1.
- done+branch_en, branch_addr=6'd40 at address 5 -> next fetch at 40, wrapped=0. done+branch_en+halt -> HALT, address stays 5.
- halt at address 3 -> halted=1, address 3 frozen across 10 cycles of done/branch noise. start -> fetch at RESET_ADDR.
- reset asserted during EXEC at address 12 -> next cycle IDLE, address=RESET_ADDR, all flags 0. start during EXEC is ignored.
- PC_CALL_STACK_EN: call at 10 to 30, ret -> fetch at 11. Five nested calls with STACK_DEPTH=4 -> stack_err=1 and halted=1.
